// File: rtl/mcycle_ctrl_if.sv
// rtl/mcycle_ctrl_if.sv - signal bundle between the multicycle controller and its datapath/memories
//   opcode, funct, zero      : instruction fields and ALU Zero flag (into the controller)
//   imem_req/imem_ready      : instruction-fetch handshake
//   dmem_req/dmem_ready/dmem_we : data-memory handshake
//   ALUOp, ALUSrc, I_format, Sftmd, Jr : ALU configuration
//   ir_we, reg_we, pc_we, pc_sel       : write strobes and next-PC select
//   state, illegal, retired            : status
interface mcycle_ctrl_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        imem_req;
  logic        imem_ready;
  logic        dmem_req;
  logic        dmem_ready;
  logic        dmem_we;
  logic [1:0]  ALUOp;
  logic        ALUSrc;
  logic        I_format;
  logic        Sftmd;
  logic        Jr;
  logic        ir_we;
  logic        reg_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic [2:0]  state;
  logic        illegal;
  logic [31:0] retired;

  modport master (
    input  opcode, funct, zero, imem_ready, dmem_ready,
    output imem_req, dmem_req, dmem_we,
    output ALUOp, ALUSrc, I_format, Sftmd, Jr,
    output ir_we, reg_we, pc_we, pc_sel,
    output state, illegal, retired
  );

  modport slave (
    output opcode, funct, zero, imem_ready, dmem_ready,
    input  imem_req, dmem_req, dmem_we,
    input  ALUOp, ALUSrc, I_format, Sftmd, Jr,
    input  ir_we, reg_we, pc_we, pc_sel,
    input  state, illegal, retired
  );
endinterface

// File: rtl/mcycle_ctrl.sv
// rtl/mcycle_ctrl.sv - multicycle processor control FSM (FETCH/DECODE/EXEC/MEM/WB)
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mcycle_ctrl_if.master, instruction fields in, handshakes, strobes, ALU controls and status out
module mcycle_ctrl (
  input logic          clk,
  input logic          rst_n,
  mcycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t      state_q;
  logic        illegal_q;
  logic [31:0] retired_q;

  // Instruction class decode
  logic is_rtype, is_jr, is_r, is_shift;
  logic is_lw, is_sw, is_beq, is_bne, is_br;
  logic is_j, is_jal, is_imm, is_legal, br_taken;

  assign is_rtype = (bus.opcode == 6'b000000);
  assign is_jr    = is_rtype && (bus.funct == 6'b001000);
  assign is_r     = is_rtype && !is_jr;
  assign is_shift = is_r && (bus.funct[5:3] == 3'b000);
  assign is_lw    = (bus.opcode == 6'b100011);
  assign is_sw    = (bus.opcode == 6'b101011);
  assign is_beq   = (bus.opcode == 6'b000100);
  assign is_bne   = (bus.opcode == 6'b000101);
  assign is_br    = is_beq || is_bne;
  assign is_j     = (bus.opcode == 6'b000010);
  assign is_jal   = (bus.opcode == 6'b000011);
  assign is_imm   = (bus.opcode[5:3] == 3'b001);
  assign is_legal = is_rtype || is_lw || is_sw || is_br || is_j || is_jal || is_imm;
  assign br_taken = (is_beq && bus.zero) || (is_bne && !bus.zero);

  // Decoded ALU configuration, only exposed in states that use the ALU
  logic [1:0] dec_aluop;

  always_comb begin
    dec_aluop = 2'b00;
    if (is_br)
      dec_aluop = 2'b01;
    else if (is_r || is_imm)
      dec_aluop = 2'b10;
  end

  // Output decode; everything is forced low while rst_n is low so reset
  // takes effect immediately, not at the next edge.
  logic       alu_en;
  logic       imem_req_c, ir_we_c, dmem_req_c, dmem_we_c;
  logic       reg_we_c, pc_we_c, retire;
  logic [1:0] pc_sel_c;

  always_comb begin
    alu_en     = 1'b0;
    imem_req_c = 1'b0;
    ir_we_c    = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    reg_we_c   = 1'b0;
    pc_we_c    = 1'b0;
    pc_sel_c   = 2'b00;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          imem_req_c = 1'b1;
          ir_we_c    = bus.imem_ready;
        end
        S_DECODE: begin
          alu_en = 1'b1;
        end
        S_EXEC: begin
          alu_en = 1'b1;
          if (!is_legal) begin
            // Unknown opcode: skip it by advancing to PC+4
            pc_we_c  = 1'b1;
            pc_sel_c = 2'b00;
          end else if (is_br) begin
            pc_we_c  = 1'b1;
            pc_sel_c = br_taken ? 2'b01 : 2'b00;
          end else if (is_j) begin
            pc_we_c  = 1'b1;
            pc_sel_c = 2'b10;
          end else if (is_jr) begin
            pc_we_c  = 1'b1;
            pc_sel_c = 2'b11;
          end
        end
        S_MEM: begin
          dmem_req_c = 1'b1;
          dmem_we_c  = is_sw;
          if (bus.dmem_ready && is_sw) begin
            pc_we_c  = 1'b1;
            pc_sel_c = 2'b00;
          end
        end
        S_WB: begin
          alu_en   = 1'b1;
          reg_we_c = 1'b1;
          pc_we_c  = 1'b1;
          // jal writes the link register here and jumps at the same time
          pc_sel_c = is_jal ? 2'b10 : 2'b00;
        end
        default: begin
        end
      endcase
    end
  end

  // An illegal opcode still moves the PC but does not count as retired
  assign retire = pc_we_c && !((state_q == S_EXEC) && !is_legal);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      retired_q <= 32'd0;
    end else begin
      if (retire)
        retired_q <= retired_q + 32'd1;
      if ((state_q == S_EXEC) && !is_legal)
        illegal_q <= 1'b1;
      case (state_q)
        S_FETCH: begin
          if (bus.imem_ready)
            state_q <= S_DECODE;
        end
        S_DECODE: begin
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (!is_legal || is_br || is_j || is_jr)
            state_q <= S_FETCH;
          else if (is_lw || is_sw)
            state_q <= S_MEM;
          else
            state_q <= S_WB;
        end
        S_MEM: begin
          if (bus.dmem_ready)
            state_q <= is_sw ? S_FETCH : S_WB;
        end
        S_WB: begin
          state_q <= S_FETCH;
        end
        default: begin
          state_q <= S_FETCH;
        end
      endcase
    end
  end

  assign bus.imem_req = imem_req_c;
  assign bus.ir_we    = ir_we_c;
  assign bus.dmem_req = dmem_req_c;
  assign bus.dmem_we  = dmem_we_c;
  assign bus.reg_we   = reg_we_c;
  assign bus.pc_we    = pc_we_c;
  assign bus.pc_sel   = pc_sel_c;
  assign bus.ALUOp    = alu_en ? dec_aluop : 2'b00;
  assign bus.ALUSrc   = alu_en && (is_lw || is_sw || is_imm);
  assign bus.I_format = alu_en && is_imm;
  assign bus.Sftmd    = alu_en && is_shift;
  assign bus.Jr       = alu_en && is_jr;
  assign bus.state    = state_q;
  assign bus.illegal  = illegal_q;
  assign bus.retired  = retired_q;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// tb/tb_mcycle_ctrl.sv - self-checking bench for mcycle_ctrl driven by per-instruction cycle schedules
module tb_mcycle_ctrl;

  logic clk;
  logic rst_n;

  mcycle_ctrl_if bus_if ();

  mcycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instruction classes as the instruction set defines them
  localparam int C_R = 0, C_SHIFT = 1, C_JR = 2, C_LW = 3, C_SW = 4, C_BEQ = 5;
  localparam int C_BNE = 6, C_J = 7, C_JAL = 8, C_IMM = 9, C_BAD = 10;

  // One expected cycle: state, outputs, ready inputs to drive, and model side effects
  // outs = {imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, pc_sel[1:0], ALUOp[1:0], ALUSrc, I_format, Sftmd, Jr}
  typedef struct {
    logic [2:0]  st;
    logic [13:0] outs;
    logic        imr;
    logic        dmr;
    logic        retire;
    logic        set_ill;
  } rec_t;

  rec_t        sched[$];
  logic [31:0] m_retired;
  logic        m_illegal;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'd0) begin
      if (fn == 6'b001000) return C_JR;
      if (fn[5:3] == 3'b000) return C_SHIFT;
      return C_R;
    end
    if (op == 6'b100011) return C_LW;
    if (op == 6'b101011) return C_SW;
    if (op == 6'b000100) return C_BEQ;
    if (op == 6'b000101) return C_BNE;
    if (op == 6'b000010) return C_J;
    if (op == 6'b000011) return C_JAL;
    if (op[5:3] == 3'b001) return C_IMM;
    return C_BAD;
  endfunction

  // {ALUOp, ALUSrc, I_format, Sftmd, Jr}
  function automatic logic [5:0] alu_bits(input int cls);
    case (cls)
      C_R:          return 6'b10_0_0_0_0;
      C_SHIFT:      return 6'b10_0_0_1_0;
      C_IMM:        return 6'b10_1_1_0_0;
      C_LW, C_SW:   return 6'b00_1_0_0_0;
      C_BEQ, C_BNE: return 6'b01_0_0_0_0;
      C_JR:         return 6'b00_0_0_0_1;
      default:      return 6'b00_0_0_0_0;
    endcase
  endfunction

  function automatic rec_t mk(input logic [2:0] st, input logic [13:0] outs,
                              input logic imr, input logic dmr, input logic ret, input logic ill);
    rec_t r;
    r.st = st; r.outs = outs; r.imr = imr; r.dmr = dmr; r.retire = ret; r.set_ill = ill;
    return r;
  endfunction

  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int iwait, input int dwait);
    int         cls;
    logic [5:0] alu;
    logic       pcwe, sw, legal;
    logic [1:0] sel;
    cls   = classify(op, fn);
    alu   = alu_bits(cls);
    legal = (cls != C_BAD);
    sw    = (cls == C_SW);
    sched.delete();
    // Fetch wait: stray dmem_ready must be ignored
    for (int i = 0; i < iwait; i++)
      sched.push_back(mk(3'd0, {1'b1, 13'b0}, 1'b0, 1'b1, 1'b0, 1'b0));
    sched.push_back(mk(3'd0, {2'b11, 12'b0}, 1'b1, 1'b1, 1'b0, 1'b0));
    sched.push_back(mk(3'd1, {6'b0, 2'b00, alu}, 1'b1, 1'b1, 1'b0, 1'b0));
    pcwe = 1'b0;
    sel  = 2'b00;
    case (cls)
      C_BAD: pcwe = 1'b1;
      C_BEQ: begin pcwe = 1'b1; sel = z ? 2'b01 : 2'b00; end
      C_BNE: begin pcwe = 1'b1; sel = z ? 2'b00 : 2'b01; end
      C_J:   begin pcwe = 1'b1; sel = 2'b10; end
      C_JR:  begin pcwe = 1'b1; sel = 2'b11; end
      default: ;
    endcase
    sched.push_back(mk(3'd2, {5'b0, pcwe, sel, alu}, 1'b1, 1'b1, pcwe && legal, !legal));
    if (cls == C_LW || cls == C_SW) begin
      for (int i = 0; i < dwait; i++)
        sched.push_back(mk(3'd3, {2'b00, 1'b1, sw, 10'b0}, 1'b1, 1'b0, 1'b0, 1'b0));
      sched.push_back(mk(3'd3, {2'b00, 1'b1, sw, 1'b0, sw, 8'b0}, 1'b1, 1'b1, sw, 1'b0));
    end
    if (cls == C_LW || cls == C_R || cls == C_SHIFT || cls == C_IMM || cls == C_JAL)
      sched.push_back(mk(3'd4, {4'b0, 2'b11, (cls == C_JAL) ? 2'b10 : 2'b00, alu},
                         1'b1, 1'b1, 1'b1, 1'b0));
  endtask

  function automatic logic [13:0] dut_outs();
    return {bus_if.imem_req, bus_if.ir_we, bus_if.dmem_req, bus_if.dmem_we,
            bus_if.reg_we, bus_if.pc_we, bus_if.pc_sel, bus_if.ALUOp,
            bus_if.ALUSrc, bus_if.I_format, bus_if.Sftmd, bus_if.Jr};
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_outs"}, {18'b0, dut_outs()}, 32'd0);
    check({tag, "_state"}, {29'b0, bus_if.state}, 32'd0);
    check({tag, "_retired"}, bus_if.retired, 32'd0);
    check({tag, "_illegal"}, {31'b0, bus_if.illegal}, 32'd0);
  endtask

  // Called just after a negedge; returns just after a later negedge.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int iwait, input int dwait, input int abort_at);
    bus_if.opcode = op;
    bus_if.funct  = fn;
    bus_if.zero   = z;
    build(op, fn, z, iwait, dwait);
    for (int k = 0; k < sched.size(); k++) begin
      bus_if.imem_ready = sched[k].imr;
      bus_if.dmem_ready = sched[k].dmr;
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_state({tag, "_abort"});
        m_retired = 32'd0;
        m_illegal = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      #1;
      check({tag, "_outs"}, {18'b0, dut_outs()}, {18'b0, sched[k].outs});
      check({tag, "_state"}, {29'b0, bus_if.state}, {29'b0, sched[k].st});
      check({tag, "_retired"}, bus_if.retired, m_retired);
      check({tag, "_illegal"}, {31'b0, bus_if.illegal}, {31'b0, m_illegal});
      if (sched[k].retire) m_retired = m_retired + 32'd1;
      if (sched[k].set_ill) m_illegal = 1'b1;
      @(negedge clk);
    end
  endtask

  int dreq_cnt;

  initial begin
    rst_n             = 1'b0;
    bus_if.opcode     = 6'd0;
    bus_if.funct      = 6'd0;
    bus_if.zero       = 1'b0;
    bus_if.imem_ready = 1'b1;
    bus_if.dmem_ready = 1'b1;
    m_retired         = 32'd0;
    m_illegal         = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    // Hand-computed pins on the schedule model
    build(6'b000000, 6'b100000, 1'b0, 0, 0);
    check("add_len", sched.size(), 32'd4);
    check("add_wb_outs", {18'b0, sched[3].outs}, {18'b0, 14'b0000_11_00_10_0000});
    build(6'b100011, 6'b000000, 1'b0, 0, 3);
    check("lw_len", sched.size(), 32'd8);
    dreq_cnt = 0;
    foreach (sched[i]) if (sched[i].outs[11]) dreq_cnt++;
    check("lw_dreq_cycles", dreq_cnt, 32'd4);
    build(6'b000100, 6'b000000, 1'b1, 0, 0);
    check("beq_exec_outs", {18'b0, sched[2].outs}, {18'b0, 14'b0000_01_01_01_0000});

    run_instr("add",  6'b000000, 6'b100000, 1'b0, 0, 0, -1);
    check("add_retired_lit", bus_if.retired, 32'd1);
    run_instr("beq_t", 6'b000100, 6'b000000, 1'b1, 0, 0, -1);
    run_instr("beq_n", 6'b000100, 6'b000000, 1'b0, 0, 0, -1);
    run_instr("bne_t", 6'b000101, 6'b000000, 1'b0, 0, 0, -1);
    run_instr("lw",   6'b100011, 6'b000000, 1'b0, 0, 3, -1);
    run_instr("sw",   6'b101011, 6'b000000, 1'b0, 0, 1, -1);
    run_instr("srav", 6'b000000, 6'b000111, 1'b0, 0, 0, -1);
    run_instr("addi", 6'b001000, 6'b010101, 1'b0, 2, 0, -1);
    run_instr("j",    6'b000010, 6'b000000, 1'b0, 0, 0, -1);
    run_instr("jal",  6'b000011, 6'b000000, 1'b0, 1, 0, -1);
    run_instr("jr",   6'b000000, 6'b001000, 1'b0, 0, 0, -1);
    check("retired_11_lit", bus_if.retired, 32'd11);
    run_instr("ill",  6'b111111, 6'b000000, 1'b0, 0, 0, -1);
    check("ill_retired_lit", bus_if.retired, 32'd11);
    check("ill_sticky_lit", {31'b0, bus_if.illegal}, 32'd1);
    run_instr("lw_rst", 6'b100011, 6'b000000, 1'b0, 0, 3, 4);
    run_instr("add2", 6'b000000, 6'b100000, 1'b0, 0, 0, -1);
    check("post_rst_retired_lit", bus_if.retired, 32'd1);

    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    m_retired = 32'hFFFF_FFFF;
    run_instr("wrap", 6'b000000, 6'b100000, 1'b0, 0, 0, -1);
    check("wrap_lit", bus_if.retired, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
